bus_master_port: RTL and testbench

BUS_MASTER_PORT -- requirements
Module: bus_master_port

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_master_port_if.sv | 30 +++
 rtl/serial_shift_reg.sv | 21 ++
 rtl/bus_master_port.sv | 124 ++++++++++++
 tb/tb_bus_master_port.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master: state encoding, default widths
// and the rd_wrt direction encoding.
package bus_pkg;
  localparam int DEF_ADDRESS_WIDTH = 15;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ID_WIDTH      = 3;
  localparam int DEF_RD_TIMEOUT    = 255;

  localparam logic RD_WRT_WRITE = 1'b1;
  localparam logic RD_WRT_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_SEND_ID, ST_SEND_ADDR,
    ST_SEND_DATA, ST_RD_WAIT, ST_RD_DATA, ST_DONE
  } bm_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/bus_master_port_if.sv
// Command/status and arbiter handshake bundle between local logic and the bus master.
interface bus_master_port_if import bus_pkg::*; #(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ID_WIDTH      = DEF_ID_WIDTH
);
  logic                     start;
  logic                     cmd_write;
  logic [ID_WIDTH-1:0]      cmd_id;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]    cmd_wdata;
  logic                     arbiter_grant;
  logic                     bus_req;
  logic                     bus_util;
  logic                     rd_wrt;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     busy;
  logic                     done;
  logic                     timeout_err;

  modport master (
    input  start, cmd_write, cmd_id, cmd_addr, cmd_wdata, arbiter_grant,
    output bus_req, bus_util, rd_wrt, rdata, busy, done, timeout_err
  );

  modport slave (
    output start, cmd_write, cmd_id, cmd_addr, cmd_wdata, arbiter_grant,
    input  bus_req, bus_util, rd_wrt, rdata, busy, done, timeout_err
  );
endinterface

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register: MSB shifts out, LSB shifts in. Used for both
// transmit (load then shift out) and receive (shift in from the line).
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)      q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= {q[WIDTH-2:0], sin};

  assign sout = q[WIDTH-1];
endmodule

// File: rtl/bus_master_port.sv
// Serial bus master: arbitrates for the shared line, sends ID/address(/data)
// MSB-first, and for reads waits for a slave start bit then shifts data in.
module bus_master_port import bus_pkg::*; #(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ID_WIDTH      = DEF_ID_WIDTH,
  parameter int RD_TIMEOUT    = DEF_RD_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstn,
  bus_master_port_if.master bif,
  inout  wire               data_bus_serial
);
  localparam int CNT_W = $clog2(max2(ADDRESS_WIDTH, RD_TIMEOUT + 1));
  localparam int SR_W  = max2(ADDRESS_WIDTH, max2(DATA_WIDTH, ID_WIDTH));
  localparam logic [CNT_W-1:0] ID_LAST   = CNT_W'(ID_WIDTH - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRESS_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(RD_TIMEOUT - 1);

  bm_state_e                state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic                     tmo_q, tmo_nxt;
  logic                     cmd_write_q;
  logic [ID_WIDTH-1:0]      cmd_id_q;
  logic [ADDRESS_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0]    cmd_wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     sr_load, sr_shift, sr_out;
  logic [SR_W-1:0]          sr_load_val, sr_q;
  logic                     line_in, drive_en, util;

  assign line_in         = data_bus_serial;
  assign data_bus_serial = drive_en ? sr_out : 1'bz;

  // Counter restarts at every state change so each state counts its own cycles.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      tmo_q <= tmo_nxt;
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cmd_write_q <= 1'b0;
      cmd_id_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else if (state == ST_IDLE && bif.start) begin
      cmd_write_q <= bif.cmd_write;
      cmd_id_q    <= bif.cmd_id;
      cmd_addr_q  <= bif.cmd_addr;
      cmd_wdata_q <= bif.cmd_wdata;
    end

  // The last data bit arrives on the same edge that leaves RD_DATA.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rdata_q <= '0;
    else if (state == ST_RD_DATA && state_nxt == ST_DONE)
      rdata_q <= DATA_WIDTH'({sr_q, line_in});

  always_comb begin
    state_nxt = state;
    tmo_nxt   = 1'b0;
    case (state)
      ST_IDLE:      if (bif.start) state_nxt = ST_REQ;
      ST_REQ:       if (bif.arbiter_grant) state_nxt = ST_SEND_ID;
      ST_SEND_ID:   if (cnt == ID_LAST) state_nxt = ST_SEND_ADDR;
      ST_SEND_ADDR: if (cnt == ADDR_LAST)
                      state_nxt = cmd_write_q ? ST_SEND_DATA : ST_RD_WAIT;
      ST_SEND_DATA: if (cnt == DATA_LAST) state_nxt = ST_DONE;
      ST_RD_WAIT:   if (!line_in) state_nxt = ST_RD_DATA;
                    else if (cnt == TMO_LAST) begin
                      state_nxt = ST_DONE;
                      tmo_nxt   = 1'b1;
                    end
      ST_RD_DATA:   if (cnt == DATA_LAST) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Transmit fields are left-aligned so the field MSB sits at the shifter MSB.
  always_comb begin
    sr_load     = 1'b0;
    sr_load_val = '0;
    if (state_nxt != state) begin
      case (state_nxt)
        ST_SEND_ID:   begin sr_load = 1'b1; sr_load_val = SR_W'(cmd_id_q)    << (SR_W - ID_WIDTH);      end
        ST_SEND_ADDR: begin sr_load = 1'b1; sr_load_val = SR_W'(cmd_addr_q)  << (SR_W - ADDRESS_WIDTH); end
        ST_SEND_DATA: begin sr_load = 1'b1; sr_load_val = SR_W'(cmd_wdata_q) << (SR_W - DATA_WIDTH);    end
        default: ;
      endcase
    end
  end

  assign sr_shift = state inside {ST_SEND_ID, ST_SEND_ADDR, ST_SEND_DATA, ST_RD_DATA};

  serial_shift_reg #(.WIDTH(SR_W)) u_sr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (sr_load),
    .load_val (sr_load_val),
    .shift    (sr_shift),
    .sin      (line_in),
    .sout     (sr_out),
    .q        (sr_q)
  );

  assign drive_en        = state inside {ST_SEND_ID, ST_SEND_ADDR, ST_SEND_DATA};
  assign util            = drive_en || state inside {ST_RD_WAIT, ST_RD_DATA};
  assign bif.bus_util    = util;
  assign bif.bus_req     = util || (state == ST_REQ);
  assign bif.rd_wrt      = (util && cmd_write_q) ? RD_WRT_WRITE : RD_WRT_READ;
  assign bif.busy        = (state != ST_IDLE);
  assign bif.done        = (state == ST_DONE);
  assign bif.timeout_err = (state == ST_DONE) && tmo_q;
  assign bif.rdata       = rdata_q;
endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench: the driver pushes the expected frame/result per command,
// a negedge monitor checks line bits, latency and completion status.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int IW  = 3;
  localparam int AW  = 15;
  localparam int DW  = 8;
  localparam int TMO = 255;

  typedef struct {
    bit        write;
    bit [25:0] frame;
    int        nbits;
    bit [7:0]  rdata;
    bit        tmo;
    int        lat;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic slv_en = 1'b0;
  logic slv_bit = 1'b1;
  wire  data_bus_serial;

  always #5 clk = ~clk;

  pullup (data_bus_serial);
  assign data_bus_serial = slv_en ? slv_bit : 1'bz;

  bus_master_port_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bif();

  bus_master_port #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RD_TIMEOUT(TMO)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .bif             (bif),
    .data_bus_serial (data_bus_serial)
  );

  exp_t     exp_q[$];
  int       checks = 0;
  int       errors = 0;
  bit [7:0] model_rdata = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: frame bits while bus_util is high, completion status on done.
  int   cyc = 0, t0 = 0, bitpos = 0;
  bit   in_frame = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      in_frame = 1'b0;
      chk("rst_done", bif.done, 0);
      chk("rst_busy", bif.busy, 0);
    end else begin
      chk("tmo_without_done", bif.timeout_err & ~bif.done, 0);
      if (bif.bus_util) begin
        chk("req_in_frame", bif.bus_req, 1);
        chk("busy_in_frame", bif.busy, 1);
        if (!in_frame) begin
          chk("unexpected_frame", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            in_frame = 1'b1;
            cur      = exp_q[0];
            t0       = cyc;
            bitpos   = 0;
          end
        end
        if (in_frame) begin
          chk("rd_wrt", bif.rd_wrt, cur.write);
          if (bitpos < cur.nbits)
            chk("frame_bit", data_bus_serial, cur.frame[cur.nbits-1-bitpos]);
          bitpos++;
        end
      end
      if (bif.done) begin
        chk("unexpected_done", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("done_latency", in_frame ? cyc - t0 : -1, cur.lat);
          chk("rdata", bif.rdata, cur.rdata);
          chk("timeout_err", bif.timeout_err, cur.tmo);
          chk("done_bus_req", bif.bus_req, 0);
          chk("done_bus_util", bif.bus_util, 0);
          chk("done_rd_wrt", bif.rd_wrt, 0);
          chk("done_line_z", data_bus_serial, 1);
          chk("done_busy", bif.busy, 1);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic do_reset(input bit check);
    rstn = 1'b0;
    #1;
    if (check) begin
      chk("rst_bus_req", bif.bus_req, 0);
      chk("rst_bus_util", bif.bus_util, 0);
      chk("rst_rd_wrt", bif.rd_wrt, 0);
      chk("rst_busy_now", bif.busy, 0);
      chk("rst_done_now", bif.done, 0);
      chk("rst_tmo", bif.timeout_err, 0);
      chk("rst_rdata", bif.rdata, 0);
      chk("rst_line_z", data_bus_serial, 1);
    end
    exp_q.delete();
    model_rdata       = 8'h00;
    bif.start         = 1'b0;
    bif.arbiter_grant = 1'b0;
    slv_en            = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // mode 0: plain, 1: stray start during SEND_ADDR, 2: reset during SEND_ADDR.
  // For reads, dat is the slave's reply; sdly < 0 means the slave stays silent.
  task automatic run_txn(input bit wr, input bit [2:0] id, input bit [14:0] addr,
                         input bit [7:0] dat, input int gdly, input int sdly,
                         input int mode);
    exp_t e;
    int   n;
    e.write = wr;
    e.frame = wr ? {id, addr, dat} : {8'h00, id, addr};
    e.nbits = wr ? IW + AW + DW : IW + AW;
    e.tmo   = 1'b0;
    e.rdata = model_rdata;
    if (wr) e.lat = IW + AW + DW;
    else if (sdly < 0) begin e.tmo = 1'b1; e.lat = IW + AW + TMO; end
    else begin e.rdata = dat; e.lat = IW + AW + sdly + 1 + DW; end

    @(posedge clk); #1;
    bif.start = 1'b1; bif.cmd_write = wr; bif.cmd_id = id;
    bif.cmd_addr = addr; bif.cmd_wdata = dat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bif.start = 1'b0;
    for (int c = 0; c < gdly; c++) begin
      chk("wait_bus_req", bif.bus_req, 1);
      chk("wait_bus_util", bif.bus_util, 0);
      chk("wait_line_z", data_bus_serial, 1);
      @(posedge clk); #1;
    end
    bif.arbiter_grant = 1'b1;
    n = 0;
    while (!bif.bus_util && n < 8) begin @(posedge clk); #1; n++; end
    chk("grant_to_frame", bif.bus_util, 1);
    if (!bif.bus_util) begin do_reset(0); return; end
    chk("grant_latency", n, 1);

    for (int h = 1; h <= IW + AW; h++) begin
      @(posedge clk); #1;
      if (h == 1) bif.arbiter_grant = 1'b0;
      if (mode == 1 && h == 6) begin
        bif.start = 1'b1; bif.cmd_write = ~wr; bif.cmd_id = ~id;
        bif.cmd_addr = ~addr; bif.cmd_wdata = ~dat;
      end
      if (mode == 1 && h == 7) bif.start = 1'b0;
      if (mode == 2 && h == 8) begin do_reset(1); return; end
    end

    if (!wr && sdly >= 0) begin
      repeat (sdly) begin @(posedge clk); #1; end
      slv_en = 1'b1; slv_bit = 1'b0;
      for (int b = DW - 1; b >= 0; b--) begin
        @(posedge clk); #1;
        slv_bit = dat[b];
      end
      @(posedge clk); #1;
      slv_en = 1'b0;
    end

    n = 0;
    while (bif.busy && n < 600) begin @(posedge clk); #1; n++; end
    chk("txn_complete", bif.busy, 0);
    if (bif.busy) begin do_reset(0); return; end
    model_rdata = e.rdata;
    @(posedge clk); #1;
    chk("stays_idle", bif.busy, 0);
  endtask

  initial begin
    bif.start = 1'b0; bif.cmd_write = 1'b0; bif.cmd_id = '0;
    bif.cmd_addr = '0; bif.cmd_wdata = '0; bif.arbiter_grant = 1'b0;
    #2;
    do_reset(1);

    run_txn(1'b1, 3'd2, 15'h0123, 8'hA5, 4, 0, 0);
    run_txn(1'b0, 3'd0, 15'h7FFF, 8'h3C, 2, 10, 0);
    run_txn(1'b0, 3'd5, 15'h1234, 8'h00, 1, -1, 0);
    run_txn(1'b0, 3'd7, 15'h0001, 8'hC3, 0, TMO - 1, 0);
    run_txn(1'b0, 3'd1, 15'h4000, 8'h81, 0, 0, 0);
    run_txn(1'b1, 3'd6, 15'h2AAA, 8'h5A, 3, 0, 1);
    run_txn(1'b0, 3'd3, 15'h5555, 8'hE7, 1, 4, 1);
    run_txn(1'b1, 3'd4, 15'h0F0F, 8'hFF, 2, 0, 2);
    run_txn(1'b1, 3'd4, 15'h70F0, 8'h01, 0, 0, 0);
    run_txn(1'b0, 3'd2, 15'h3333, 8'h99, 100, 7, 0);

    for (int i = 0; i < 14; i++) begin
      bit wr;
      int sd;
      wr = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 30));
      run_txn(wr, 3'($urandom), 15'($urandom), 8'($urandom),
              int'($urandom_range(0, 6)), sd, 0);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
